// File: rtl/regio_arbiter_pkg.sv
// Shared regIO arbiter constants: regIO state codes, the idle view code, FSM encoding and a pointer helper.
package regio_arbiter_pkg;

   localparam logic [3:0] RIO_ADDR0  = 4'h0;
   localparam logic [3:0] RIO_ADDR1  = 4'h1;
   localparam logic [3:0] RIO_ADDR2  = 4'h2;
   localparam logic [3:0] RIO_ADDR3  = 4'h3;
   localparam logic [3:0] RIO_READ0  = 4'h4;
   localparam logic [3:0] RIO_READ1  = 4'h5;
   localparam logic [3:0] RIO_WRITE0 = 4'h6;
   localparam logic [3:0] RIO_WRITE1 = 4'h7;
   localparam logic [3:0] RIO_DUMMY  = 4'h8;
   localparam logic [3:0] RIO_WAIT   = 4'h9;

   // Never produced by regIO, so a requester seeing it knows it does not own the bus.
   localparam logic [3:0] RIO_IDLE_STATE = 4'hF;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ARB   = 2'd1,
      ARB_OWN   = 2'd2,
      ARB_DRAIN = 2'd3
   } arb_state_t;

   function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
      logic [3:0] nxt;
      nxt = {1'b0, idx} + 4'd1;
      if (int'(nxt) >= n) nxt = 4'd0;
      return nxt[2:0];
   endfunction

endpackage

// File: rtl/regio_arbiter_pick.sv
// Combinational winner selector: first set req bit found scanning upward from the start index (ptr in
// round-robin mode, 0 otherwise), wrapping at NUM_REQ. ptr must be below NUM_REQ.
module regio_arb_pick #(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [2:0]         ptr,
   input  logic               rr_en,
   output logic [NUM_REQ-1:0] gnt_oh,
   output logic [2:0]         idx,
   output logic               vld
);

   always_comb begin : scan
      int j;
      gnt_oh = '0;
      idx    = '0;
      vld    = 1'b0;
      j      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = k + (rr_en ? int'(ptr) : 0);
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!vld && req[j]) begin
            vld       = 1'b1;
            gnt_oh[j] = 1'b1;
            idx       = 3'(j);
         end
      end
   end

endmodule

// File: rtl/regio_arbiter.sv
// Shares regIO among NUM_REQ requesters, one session per grant; REGIO_ARB_RR_EN selects round-robin, else fixed priority.
// Grant 2 cycles after req, command mux and state fan-out add 0 cycles; release waits for regIO Wait, long sessions time out.
module regio_arbiter
   import regio_arbiter_pkg::*;
#(
   parameter int         NUM_REQ     = 3,
   parameter int         TIMEOUT_CYC = 65535,
   parameter logic [3:0] IDLE_STATE  = RIO_IDLE_STATE
) (
   input  logic                    sysclk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req,
   output logic [NUM_REQ-1:0]      gnt,
   input  logic [8*NUM_REQ-1:0]    req_offset,
   input  logic [NUM_REQ-1:0]      req_length,
   input  logic [NUM_REQ-1:0]      req_wr,
   input  logic [16*NUM_REQ-1:0]   req_wdata,
   input  logic [NUM_REQ-1:0]      req_newcmd,
   input  logic [NUM_REQ-1:0]      req_dummy,
   output logic [7:0]              offset,
   output logic                    length,
   output logic                    WR,
   output logic [15:0]             writeData,
   output logic                    NewCommand,
   output logic                    Dummy_Read,
   input  logic [3:0]              state,
   output logic [4*NUM_REQ-1:0]    req_state,
   output logic [2:0]              owner,
   output logic                    timeout_err,
   output logic                    timeout_sticky
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

   arb_state_t          cur_st;
   arb_state_t          nxt_st;
   logic [15:0]         cnt;
   logic [NUM_REQ-1:0]  last_gnt;
   logic [NUM_REQ-1:0]  req_excl;
   logic [NUM_REQ-1:0]  cand;
   logic [NUM_REQ-1:0]  win_gnt;
   logic [2:0]          win_idx;
   logic                win_vld;
   logic [2:0]          ptr;
   logic                owner_req;
   logic                arb_load;
   logic                to_fire;
   logic                bus_free;

   // The previous owner only competes when nobody else is asking.
   assign req_excl  = req & ~last_gnt;
   assign cand      = (req_excl != '0) ? req_excl : req;
   assign owner_req = |(req & gnt);

`ifdef REGIO_ARB_RR_EN
   localparam logic RR_EN = 1'b1;

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         ptr <= '0;
      end else if (arb_load) begin
         ptr <= wrap_inc(win_idx, NUM_REQ);
      end
   end
`else
   localparam logic RR_EN = 1'b0;

   assign ptr = '0;
`endif

   regio_arb_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req    (cand),
      .ptr    (ptr),
      .rr_en  (RR_EN),
      .gnt_oh (win_gnt),
      .idx    (win_idx),
      .vld    (win_vld)
   );

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         cur_st <= ARB_IDLE;
      end else begin
         cur_st <= nxt_st;
      end
   end

   always_comb begin
      nxt_st   = cur_st;
      arb_load = 1'b0;
      to_fire  = 1'b0;
      bus_free = 1'b0;
      case (cur_st)
         ARB_IDLE: begin
            if (|req) nxt_st = ARB_ARB;
         end
         ARB_ARB: begin
            // All requests may have vanished since IDLE; fall back rather than grant nobody.
            if (win_vld) begin
               arb_load = 1'b1;
               nxt_st   = ARB_OWN;
            end else begin
               nxt_st = ARB_IDLE;
            end
         end
         ARB_OWN: begin
            if (!owner_req) begin
               nxt_st = ARB_DRAIN;
            end else if (cnt == TO_LAST) begin
               to_fire = 1'b1;
               nxt_st  = ARB_DRAIN;
            end
         end
         ARB_DRAIN: begin
            if (state == RIO_WAIT) begin
               bus_free = 1'b1;
               nxt_st   = ARB_IDLE;
            end
         end
         default: nxt_st = ARB_IDLE;
      endcase
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         gnt            <= '0;
         owner          <= '0;
         cnt            <= '0;
         last_gnt       <= '0;
         timeout_err    <= 1'b0;
         timeout_sticky <= 1'b0;
      end else begin
         timeout_err <= to_fire;
         if (to_fire) timeout_sticky <= 1'b1;
         if (arb_load) begin
            gnt      <= win_gnt;
            owner    <= win_idx;
            last_gnt <= win_gnt;
            cnt      <= '0;
         end else if (cur_st == ARB_OWN && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
         end
         if (bus_free) gnt <= '0;
      end
   end

   // While draining, address/data stay on the owner but nothing new may be launched.
   always_comb begin
      offset     = '0;
      length     = 1'b0;
      WR         = 1'b0;
      writeData  = '0;
      NewCommand = 1'b0;
      Dummy_Read = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            offset    = req_offset[8*i +: 8];
            length    = req_length[i];
            writeData = req_wdata[16*i +: 16];
            if (cur_st != ARB_DRAIN) begin
               WR         = req_wr[i];
               NewCommand = req_newcmd[i];
               Dummy_Read = req_dummy[i];
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_view
      assign req_state[4*i +: 4] = gnt[i] ? state : IDLE_STATE;
   end

endmodule

// File: tb/tb_regio_arbiter.sv
// Directed bench for regio_arbiter (3 requesters, 20-cycle timeout) with a grant-order scoreboard.
`timescale 1ns/1ps
module tb_regio_arbiter;

   localparam int         N     = 3;
   localparam logic [3:0] WAIT_C = 4'b1001;
   localparam logic [3:0] RD1_C  = 4'h5;

   logic              sysclk;
   logic              reset;
   logic [N-1:0]      req;
   logic [N-1:0]      gnt;
   logic [8*N-1:0]    req_offset;
   logic [N-1:0]      req_length;
   logic [N-1:0]      req_wr;
   logic [16*N-1:0]   req_wdata;
   logic [N-1:0]      req_newcmd;
   logic [N-1:0]      req_dummy;
   logic [7:0]        offset;
   logic              length;
   logic              WR;
   logic [15:0]       writeData;
   logic              NewCommand;
   logic              Dummy_Read;
   logic [3:0]        state;
   logic [4*N-1:0]    req_state;
   logic [2:0]        owner;
   logic              timeout_err;
   logic              timeout_sticky;

   int checks   = 0;
   int failures = 0;
   logic [2:0] exp_q[$];

   regio_arbiter #(
      .NUM_REQ     (N),
      .TIMEOUT_CYC (20),
      .IDLE_STATE  (4'hF)
   ) dut (
      .sysclk         (sysclk),
      .reset          (reset),
      .req            (req),
      .gnt            (gnt),
      .req_offset     (req_offset),
      .req_length     (req_length),
      .req_wr         (req_wr),
      .req_wdata      (req_wdata),
      .req_newcmd     (req_newcmd),
      .req_dummy      (req_dummy),
      .offset         (offset),
      .length         (length),
      .WR             (WR),
      .writeData      (writeData),
      .NewCommand     (NewCommand),
      .Dummy_Read     (Dummy_Read),
      .state          (state),
      .req_state      (req_state),
      .owner          (owner),
      .timeout_err    (timeout_err),
      .timeout_sticky (timeout_sticky)
   );

   initial begin
      sysclk = 1'b0;
      forever #5 sysclk = ~sysclk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=no_finish required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic wait_gnt(input int limit, output int cyc);
      cyc = 0;
      while (gnt == '0 && cyc < limit) begin
         tick();
         cyc++;
      end
   endtask

   task automatic wait_free(input int limit, output int cyc);
      cyc = 0;
      while (gnt != '0 && cyc < limit) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      int e;
      reset      = 1'b0;
      req        = '0;
      state      = WAIT_C;
      req_offset = {8'hA2, 8'h92, 8'h11};
      req_wdata  = {16'hC0DE, 16'hBEEF, 16'h1234};
      req_length = 3'b010;
      req_wr     = 3'b101;
      req_newcmd = 3'b111;
      req_dummy  = 3'b010;
      #1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_bus", {offset, writeData, 4'h0, length, WR, NewCommand, Dummy_Read}, 0);
      chk("rst_view", 32'(req_state), 32'hFFF);
      chk("rst_to", {30'h0, timeout_err, timeout_sticky}, 0);
      repeat (2) tick();
      reset = 1'b1;
      tick();

      // req0 and req2 together: req0 first, req2 exactly four cycles after req0 drops
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd2);
      req = 3'b101;
      wait_gnt(8, cyc);
      chk("a_lat", 32'(cyc), 2);
      e = int'(exp_q.pop_front());
      chk("a_first", 32'(gnt), 32'(1) << e);
      repeat (3) tick();
      req[0] = 1'b0;
      cyc = 0;
      while (gnt != 3'b100 && cyc < 10) begin
         tick();
         cyc++;
      end
      chk("a_gap", 32'(cyc), 4);
      e = int'(exp_q.pop_front());
      chk("a_second", 32'(gnt), 32'(1) << e);
      chk("a_owner", 32'(owner), 32'(e));
      req = '0;
      wait_free(6, cyc);
      chk("a_free", 32'(gnt), 0);

      // req1 alone: fields and state view
      req = 3'b010;
      tick();
      chk("b_nogrant_yet", 32'(gnt), 0);
      tick();
      chk("b_gnt", 32'(gnt), 32'h2);
      chk("b_owner", 32'(owner), 1);
      chk("b_offset", 32'(offset), 32'h92);
      chk("b_wr", 32'(WR), 0);
      chk("b_wdata", 32'(writeData), 32'hBEEF);
      chk("b_ctl", {29'h0, length, NewCommand, Dummy_Read}, 32'h7);
      chk("b_view_wait", 32'(req_state), 32'hF9F);
      state = RD1_C;
      #1;
      chk("b_view_rd1", 32'(req_state), 32'hF5F);
      state = WAIT_C;
      req   = '0;
      tick();
      chk("b_drain_gnt", 32'(gnt), 32'h2);
      chk("b_drain_cmd", 32'(NewCommand), 0);
      tick();
      chk("b_free", 32'(gnt), 0);
      chk("b_free_bus", {offset, writeData, 8'h0}, 0);
      chk("b_free_view", 32'(req_state), 32'hFFF);

      // release while regIO is mid-transfer: grant held until Wait
      req = 3'b001;
      wait_gnt(8, cyc);
      chk("c_gnt", 32'(gnt), 32'h1);
      chk("c_wr", 32'(WR), 1);
      state = RD1_C;
      req   = '0;
      tick();
      chk("c_hold_gnt", 32'(gnt), 32'h1);
      chk("c_hold_cmd", {30'h0, NewCommand, WR}, 0);
      repeat (2) begin
         tick();
         chk("c_hold_more", 32'(gnt), 32'h1);
      end
      state = WAIT_C;
      tick();
      chk("c_free", 32'(gnt), 0);

      // asynchronous reset mid-session
      req = 3'b100;
      wait_gnt(8, cyc);
      chk("d_gnt", 32'(gnt), 32'h4);
      tick();
      #3;
      reset = 1'b0;
      #1;
      chk("d_rst_gnt", 32'(gnt), 0);
      chk("d_rst_owner", 32'(owner), 0);
      chk("d_rst_bus", {offset, writeData, 4'h0, length, WR, NewCommand, Dummy_Read}, 0);
      chk("d_rst_view", 32'(req_state), 32'hFFF);
      req = '0;
      tick();
      reset = 1'b1;
      tick();

      // three continuous requesters, 10-cycle sessions
      for (int s = 0; s < 6; s++) begin
`ifdef REGIO_ARB_RR_EN
         exp_q.push_back(3'(s % 3));
`else
         exp_q.push_back(3'(s % 2));
`endif
      end
      req = 3'b111;
      for (int s = 0; s < 6; s++) begin
         wait_gnt(8, cyc);
         chk("e_lat", 32'(cyc), 2);
         e = int'(exp_q.pop_front());
         chk("e_order_gnt", 32'(gnt), 32'(1) << e);
         chk("e_order_owner", 32'(owner), 32'(e));
         repeat (9) tick();
         if (s == 5) req = '0;
         else req[e] = 1'b0;
         wait_free(6, cyc);
         chk("e_free", 32'(gnt), 0);
         if (s != 5) req[e] = 1'b1;
      end

      // timeout with a single requester that never lets go
      chk("f_sticky_pre", 32'(timeout_sticky), 0);
      req = 3'b001;
      wait_gnt(8, cyc);
      chk("f_gnt", 32'(gnt), 32'h1);
      repeat (19) tick();
      chk("f_no_err_yet", {30'h0, timeout_err, timeout_sticky}, 0);
      chk("f_still_own", 32'(gnt), 32'h1);
      tick();
      chk("f_err", {30'h0, timeout_err, timeout_sticky}, 32'h3);
      chk("f_drain_cmd", 32'(NewCommand), 0);
      tick();
      chk("f_err_pulse", {30'h0, timeout_err, timeout_sticky}, 32'h1);
      chk("f_revoked", 32'(gnt), 0);
      wait_gnt(8, cyc);
      chk("f_regrant_lat", 32'(cyc), 2);
      chk("f_regrant", 32'(gnt), 32'h1);
      req = '0;
      wait_free(6, cyc);
      chk("f_free", 32'(gnt), 0);
      chk("f_sticky_hold", 32'(timeout_sticky), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
